// File: rtl/fwd_clk_monitor.sv
`default_nettype none
// ============================================================================
// Module   : fwd_clk_monitor
// Purpose  : Receive-side monitor for a forwarded clock. The forwarded clock
//            is treated as asynchronous data in the clk domain: it is
//            synchronized, its rising edges are counted over a fixed window
//            of clk cycles, and each window is qualified against the band
//            [EXP_MIN, EXP_MAX]. clk_ok asserts after LOCK_WINDOWS
//            consecutive good windows; a bad window while locked drops
//            clk_ok and pulses loss.
// Ports    : clk          local clock (forwarded clock must be < clk/2)
//            rst_n        asynchronous active-low reset
//            enable       monitor enable, synchronous to clk
//            fwd_clk_in   forwarded clock, asynchronous to clk
//            clk_ok       forwarded clock qualified (registered)
//            edge_count   edge count of the last completed window
//            window_done  one-cycle pulse when edge_count updates
//            loss         one-cycle pulse when clk_ok falls on a bad window
//            loss_clr     (FWD_CLK_LOSS_STICKY_EN only) clears loss_sticky
//            loss_sticky  (FWD_CLK_LOSS_STICKY_EN only) latched loss flag
// Options  : define FWD_CLK_LOSS_STICKY_EN to add loss_clr / loss_sticky.
// Revision : 1.0  initial release
// ============================================================================
module fwd_clk_monitor #(
    parameter int WINDOW       = 1024,
    parameter int EXP_MIN      = 250,
    parameter int EXP_MAX      = 262,
    parameter int LOCK_WINDOWS = 4,
    parameter int CW           = 11
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    input  logic          fwd_clk_in,
`ifdef FWD_CLK_LOSS_STICKY_EN
    input  logic          loss_clr,
    output logic          loss_sticky,
`endif
    output logic          clk_ok,
    output logic [CW-1:0] edge_count,
    output logic          window_done,
    output logic          loss
);

    localparam int c_win_w = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int c_good_w = $clog2(LOCK_WINDOWS + 1);
    localparam logic [c_win_w-1:0] c_win_last = c_win_w'(WINDOW - 1);
    localparam logic [CW-1:0] c_cnt_max = {CW{1'b1}};
    localparam logic [CW-1:0] c_exp_min = CW'(EXP_MIN);
    localparam logic [CW-1:0] c_exp_max = CW'(EXP_MAX);
    localparam logic [c_good_w-1:0] c_lock_n = c_good_w'(LOCK_WINDOWS);

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    logic                sync1_q, sync1_d;
    logic                sync2_q, sync2_d;
    logic                prev_q, prev_d;
    logic [c_win_w-1:0]  win_q, win_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [c_good_w-1:0] good_q, good_d;
    state_t              state_q, state_d;
    logic                clk_ok_q, clk_ok_d;
    logic [CW-1:0]       edge_count_q, edge_count_d;
    logic                done_q, done_d;
    logic                loss_q, loss_d;

    logic                w_edge_det;
    logic [CW-1:0]       w_final_cnt;
    logic                w_win_end;
    logic                w_good;
    logic [c_good_w-1:0] w_good_inc;

    // Edge detect sits behind the 2-flop synchronizer; prev_q is the
    // delayed copy used only for the rising-edge compare.
    assign w_edge_det  = sync2_q & ~prev_q;
    // Count including an edge on this very cycle, saturating so an overflow
    // still reads as above EXP_MAX rather than wrapping into the good band.
    assign w_final_cnt = (w_edge_det && (cnt_q != c_cnt_max)) ? cnt_q + CW'(1) : cnt_q;
    assign w_win_end   = enable && (win_q == c_win_last);
    assign w_good      = (w_final_cnt >= c_exp_min) && (w_final_cnt <= c_exp_max);
    assign w_good_inc  = good_q + c_good_w'(1);

    always_comb begin
        sync1_d      = fwd_clk_in;
        sync2_d      = sync1_q;
        prev_d       = sync2_q;
        win_d        = win_q;
        cnt_d        = cnt_q;
        good_d       = good_q;
        state_d      = state_q;
        edge_count_d = edge_count_q;
        done_d       = 1'b0;
        loss_d       = 1'b0;

        if (!enable) begin
            win_d   = '0;
            cnt_d   = '0;
            good_d  = '0;
            state_d = ST_SEARCH;
        end else if (w_win_end) begin
            win_d        = '0;
            cnt_d        = '0;
            edge_count_d = w_final_cnt;
            done_d       = 1'b1;
            case (state_q)
                ST_SEARCH: begin
                    if (w_good) begin
                        if (LOCK_WINDOWS == 1) begin
                            state_d = ST_LOCKED;
                            good_d  = '0;
                        end else begin
                            state_d = ST_ACQUIRE;
                            good_d  = c_good_w'(1);
                        end
                    end
                end
                ST_ACQUIRE: begin
                    if (w_good) begin
                        good_d = w_good_inc;
                        if (w_good_inc == c_lock_n) begin
                            state_d = ST_LOCKED;
                        end
                    end else begin
                        state_d = ST_SEARCH;
                        good_d  = '0;
                    end
                end
                ST_LOCKED: begin
                    if (!w_good) begin
                        state_d = ST_SEARCH;
                        good_d  = '0;
                        loss_d  = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_SEARCH;
                    good_d  = '0;
                end
            endcase
        end else begin
            win_d = win_q + c_win_w'(1);
            cnt_d = w_final_cnt;
        end

        // State only moves at a window end or on disable, so clk_ok lines up
        // with window_done (or drops straight away on disable).
        clk_ok_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            prev_q       <= 1'b0;
            win_q        <= '0;
            cnt_q        <= '0;
            good_q       <= '0;
            state_q      <= ST_SEARCH;
            clk_ok_q     <= 1'b0;
            edge_count_q <= '0;
            done_q       <= 1'b0;
            loss_q       <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            prev_q       <= prev_d;
            win_q        <= win_d;
            cnt_q        <= cnt_d;
            good_q       <= good_d;
            state_q      <= state_d;
            clk_ok_q     <= clk_ok_d;
            edge_count_q <= edge_count_d;
            done_q       <= done_d;
            loss_q       <= loss_d;
        end
    end

    assign clk_ok      = clk_ok_q;
    assign edge_count  = edge_count_q;
    assign window_done = done_q;
    assign loss        = loss_q;

`ifdef FWD_CLK_LOSS_STICKY_EN
    logic loss_sticky_q, loss_sticky_d;

    // Set has priority over clear; set is taken from loss_d so the sticky
    // flag rises together with the loss pulse.
    always_comb begin
        loss_sticky_d = loss_d | (loss_sticky_q & ~loss_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loss_sticky_q <= 1'b0;
        end else begin
            loss_sticky_q <= loss_sticky_d;
        end
    end

    assign loss_sticky = loss_sticky_q;
`endif

endmodule
`default_nettype wire
